pulp_io_apb_master: RTL and testbench
=====================================

# pulp_io_apb_master

Register-access initiator for the two APB slave ports of the pulp_io peripheral subsystem (uDMA config and GPIO). It accepts one 32-bit read/write request at a time on a valid/ready port and decodes the address to one of two APB windows. It runs a standard SETUP/ACCESS APB transfer on that window and returns the read data and error status on a valid/ready response port. It sits between the SoC-side command source (debug bridge, boot sequencer, or test harness) and pulp_io.

## Interface
- APB_ADDR_WIDTH, 12: width of each APB paddr; each window spans 2^APB_ADDR_WIDTH bytes.
- UDMA_BASE, 32'h1A10_2000: uDMA window base; aligned to 2^APB_ADDR_WIDTH.
- GPIO_BASE, 32'h1A10_1000: GPIO window base; aligned to 2^APB_ADDR_WIDTH.
- TIMEOUT_CYCLES, 255: maximum ACCESS-phase cycles without pready; 0 disables the timeout.
- sys_clk_i  in  1  clock. One clock only; everything is on the rising edge.
- sys_rst_ni  in  1  reset. Synchronous and active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_addr_i  in  32  byte address.
- req_write_i  in  1  1 = write, 0 = read.
- req_wdata_i  in  32  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_rdata_o  out  32  read data.
- rsp_err_o  out  1  error: pslverr, decode miss, or timeout.
- udma_apb_paddr  out  APB_ADDR_WIDTH  address to the uDMA port.
- udma_apb_pwdata  out  32  write data to the uDMA port.
- udma_apb_pwrite  out  1  write flag to the uDMA port.
- udma_apb_psel  out  1  select for the uDMA port.
- udma_apb_penable  out  1  enable for the uDMA port.
- udma_apb_prdata  in  32  read data from the uDMA port.
- udma_apb_pready  in  1  ready from the uDMA port.
- udma_apb_pslverr  in  1  slave error from the uDMA port.
- gpio_apb_paddr, gpio_apb_pwdata, gpio_apb_pwrite, gpio_apb_psel, gpio_apb_penable, gpio_apb_prdata, gpio_apb_pready, gpio_apb_pslverr: same directions, widths and meanings as the udma_apb_* ports, for the GPIO port.
- busy_o  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - req_ready_o=1.
  - On req_valid_i&req_ready_o, latch addr, write and wdata, and decode the address:
    - hit = addr[31:APB_ADDR_WIDTH]==BASE[31:APB_ADDR_WIDTH].
    - If both windows hit, uDMA wins.
  - Hit -> SETUP.
  - Miss -> RESP with err=1 and rdata=0. No APB activity occurs.
- **SETUP**
  - Selected target: psel=1, penable=0.
  - Go to ACCESS unconditionally.
- **ACCESS**
  - Selected target: psel=1, penable=1.
  - Timeout counter increments each ACCESS cycle without pready.
  - On pready=1:
    - capture rdata = prdata for reads, 0 for writes;
    - capture err = pslverr;
    - -> RESP.
  - If the counter reaches TIMEOUT_CYCLES (nonzero) without pready:
    - drop psel/penable;
    - err=1, rdata=0;
    - -> RESP. The transfer is abandoned.
- **RESP**
  - rsp_valid_o=1. rsp_rdata_o and rsp_err_o are held stable.
  - On rsp_ready_i -> IDLE.
- paddr, pwdata and pwrite come from the latched request and are driven identically to both ports. paddr = addr[APB_ADDR_WIDTH-1:0].
- These outputs are stable from SETUP through the end of ACCESS. The non-selected port's psel and penable stay 0.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1). It is cleared on entry to SETUP.

## Timing
- **Reset values** (after the first edge with sys_rst_ni=0):
  - state=IDLE;
  - all psel, penable, paddr, pwdata, pwrite = 0;
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0;
  - busy_o=0;
  - req_ready_o=1, because it is decoded from state IDLE.
- **Latency**
  - Request accepted in cycle 0, SETUP in cycle 1, ACCESS in cycle 2.
  - With pready=1 in cycle 2, rsp_valid_o=1 in cycle 3. Each wait state adds 1 cycle.
  - Decode miss: rsp_valid_o=1 in cycle 1.
- **Throughput**: one outstanding request. req_ready_o returns to 1 in the cycle after the rsp handshake.
- **Response hold**: rsp_valid_o is not retracted once raised. With rsp_ready_i held low, the FSM stays in RESP indefinitely.
- **Reset mid-operation**: at the reset edge psel/penable drop and the FSM enters IDLE. The pending response is discarded and no rsp_valid_o is emitted.
- **Timeout**: with TIMEOUT_CYCLES=N and pready held low, ACCESS lasts N cycles, then RESP is entered with err=1.

## Test plan
- Read 0x1A10_2010, uDMA pready=1 immediately, prdata=32'hCAFE_0001 -> udma_apb_paddr=12'h010 with psel in cycles 1-2 and penable in cycle 2; rsp_valid in cycle 3 with rdata=CAFE_0001, err=0; gpio_apb_psel stays 0.
- Write 0x1A10_1004 with data 0x0000_00FF, GPIO with 2 wait states -> pwrite=1 and pwdata stable for 4 cycles; rsp_valid in cycle 5 with rdata=0, err=0.
- Read 0x2000_0000 -> no psel on either port; rsp_valid in cycle 1 with err=1, rdata=0.
- uDMA read with pready=1 and pslverr=1 -> err=1, rdata=prdata.
- TIMEOUT_CYCLES=4, pready held 0 -> psel drops after 4 ACCESS cycles; rsp err=1, rdata=0.
- rsp_ready_i held 0 for 10 cycles, then reset asserted mid-ACCESS on a second request -> first response held stable for all 10 cycles. After the reset edge: IDLE, req_ready_o=1, no rsp_valid.

Source files
------------

// File: rtl/pulp_io_apb_master.sv
// rtl/pulp_io_apb_master.sv - single-request APB initiator for the pulp_io uDMA and GPIO slave windows
module pulp_io_apb_master #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter logic [31:0] UDMA_BASE      = 32'h1A10_2000,
    parameter logic [31:0] GPIO_BASE      = 32'h1A10_1000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      sys_clk_i,
    input  logic                      sys_rst_ni,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [31:0]               req_addr_i,
    input  logic                      req_write_i,
    input  logic [31:0]               req_wdata_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,

    output logic [APB_ADDR_WIDTH-1:0] udma_apb_paddr,
    output logic [31:0]               udma_apb_pwdata,
    output logic                      udma_apb_pwrite,
    output logic                      udma_apb_psel,
    output logic                      udma_apb_penable,
    input  logic [31:0]               udma_apb_prdata,
    input  logic                      udma_apb_pready,
    input  logic                      udma_apb_pslverr,

    output logic [APB_ADDR_WIDTH-1:0] gpio_apb_paddr,
    output logic [31:0]               gpio_apb_pwdata,
    output logic                      gpio_apb_pwrite,
    output logic                      gpio_apb_psel,
    output logic                      gpio_apb_penable,
    input  logic [31:0]               gpio_apb_prdata,
    input  logic                      gpio_apb_pready,
    input  logic                      gpio_apb_pslverr,

    output logic                      busy_o
);

    // A zero TIMEOUT_CYCLES still needs a legal one-bit counter.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e                    r_state;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [31:0]               r_pwdata;
    logic                      r_pwrite;
    logic                      r_psel;
    logic                      r_penable;
    logic                      r_tgt_udma;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_rsp_valid;
    logic [31:0]               r_rsp_rdata;
    logic                      r_rsp_err;

    logic                      w_udma_hit;
    logic                      w_gpio_hit;
    logic                      w_pready;
    logic                      w_pslverr;
    logic [31:0]               w_prdata;
    logic [CNT_W-1:0]          w_cnt_next;
    logic                      w_timeout;

    assign w_udma_hit = (req_addr_i[31:APB_ADDR_WIDTH] == UDMA_BASE[31:APB_ADDR_WIDTH]);
    assign w_gpio_hit = (req_addr_i[31:APB_ADDR_WIDTH] == GPIO_BASE[31:APB_ADDR_WIDTH]);

    assign w_pready   = r_tgt_udma ? udma_apb_pready  : gpio_apb_pready;
    assign w_pslverr  = r_tgt_udma ? udma_apb_pslverr : gpio_apb_pslverr;
    assign w_prdata   = r_tgt_udma ? udma_apb_prdata  : gpio_apb_prdata;

    assign w_cnt_next = r_cnt + 1'b1;
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni) begin
            r_state     <= S_IDLE;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_tgt_udma  <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_paddr  <= req_addr_i[APB_ADDR_WIDTH-1:0];
                        r_pwdata <= req_wdata_i;
                        r_pwrite <= req_write_i;
                        if (w_udma_hit || w_gpio_hit) begin
                            r_tgt_udma <= w_udma_hit;
                            r_psel     <= 1'b1;
                            r_penable  <= 1'b0;
                            r_cnt      <= '0;
                            r_state    <= S_SETUP;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (w_pready) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? 32'h0 : w_prdata;
                        r_rsp_err   <= w_pslverr;
                        r_state     <= S_RESP;
                    end else if (w_timeout) begin
                        // Abandon the transfer; the slave never answered.
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o      = (r_state == S_IDLE);
    assign busy_o           = (r_state != S_IDLE);
    assign rsp_valid_o      = r_rsp_valid;
    assign rsp_rdata_o      = r_rsp_rdata;
    assign rsp_err_o        = r_rsp_err;

    assign udma_apb_paddr   = r_paddr;
    assign udma_apb_pwdata  = r_pwdata;
    assign udma_apb_pwrite  = r_pwrite;
    assign udma_apb_psel    = r_psel & r_tgt_udma;
    assign udma_apb_penable = r_penable & r_tgt_udma;

    assign gpio_apb_paddr   = r_paddr;
    assign gpio_apb_pwdata  = r_pwdata;
    assign gpio_apb_pwrite  = r_pwrite;
    assign gpio_apb_psel    = r_psel & ~r_tgt_udma;
    assign gpio_apb_penable = r_penable & ~r_tgt_udma;

endmodule

// File: tb/tb_pulp_io_apb_master.sv
// tb/tb_pulp_io_apb_master.sv - directed self-checking bench for pulp_io_apb_master
module tb_pulp_io_apb_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [11:0] u_paddr, g_paddr;
    logic [31:0] u_pwdata, g_pwdata, u_prdata, g_prdata;
    logic        u_pwrite, u_psel, u_penable, u_pready, u_pslverr;
    logic        g_pwrite, g_psel, g_penable, g_pready, g_pslverr;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    pulp_io_apb_master #(
        .APB_ADDR_WIDTH(12),
        .UDMA_BASE(32'h1A10_2000),
        .GPIO_BASE(32'h1A10_1000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .sys_clk_i(clk), .sys_rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .udma_apb_paddr(u_paddr), .udma_apb_pwdata(u_pwdata), .udma_apb_pwrite(u_pwrite),
        .udma_apb_psel(u_psel), .udma_apb_penable(u_penable), .udma_apb_prdata(u_prdata),
        .udma_apb_pready(u_pready), .udma_apb_pslverr(u_pslverr),
        .gpio_apb_paddr(g_paddr), .gpio_apb_pwdata(g_pwdata), .gpio_apb_pwrite(g_pwrite),
        .gpio_apb_psel(g_psel), .gpio_apb_penable(g_penable), .gpio_apb_prdata(g_prdata),
        .gpio_apb_pready(g_pready), .gpio_apb_pslverr(g_pslverr),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b1; req_addr = 32'h1A10_2010; req_write = 1'b1;
        req_wdata = 32'hFFFF_FFFF; rsp_ready = 1'b0;
        tick();
        if ({u_psel, u_penable, g_psel, g_penable} !== 4'b0) begin $display("FAIL rst_psel got=%b exp=0000", {u_psel, u_penable, g_psel, g_penable}); n_err++; end n_vec++;
        if ({u_paddr, u_pwdata, u_pwrite} !== 45'h0) begin $display("FAIL rst_apb_bus got=%h exp=0", {u_paddr, u_pwdata, u_pwrite}); n_err++; end n_vec++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin $display("FAIL rst_rsp got=%h exp=0", {rsp_valid, rsp_err, rsp_rdata}); n_err++; end n_vec++;
        if (busy !== 1'b0) begin $display("FAIL rst_busy got=%b exp=0", busy); n_err++; end n_vec++;
        if (req_ready !== 1'b1) begin $display("FAIL rst_req_ready got=%b exp=1", req_ready); n_err++; end n_vec++;
        req_valid = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_udma_read;
        u_pready = 1'b1; u_pslverr = 1'b0; u_prdata = 32'hCAFE_0001;
        req_valid = 1'b1; req_addr = 32'h1A10_2010; req_write = 1'b0; req_wdata = 32'h0;
        if (req_ready !== 1'b1) begin $display("FAIL rd_ready_c0 got=%b exp=1", req_ready); n_err++; end n_vec++;
        tick();
        req_valid = 1'b0;
        if ({u_psel, u_penable} !== 2'b10) begin $display("FAIL rd_setup got=%b exp=10", {u_psel, u_penable}); n_err++; end n_vec++;
        if (u_paddr !== 12'h010) begin $display("FAIL rd_paddr got=%h exp=010", u_paddr); n_err++; end n_vec++;
        if (busy !== 1'b1) begin $display("FAIL rd_busy got=%b exp=1", busy); n_err++; end n_vec++;
        tick();
        if ({u_psel, u_penable} !== 2'b11) begin $display("FAIL rd_access got=%b exp=11", {u_psel, u_penable}); n_err++; end n_vec++;
        if (g_psel !== 1'b0) begin $display("FAIL rd_gpio_psel got=%b exp=0", g_psel); n_err++; end n_vec++;
        if (rsp_valid !== 1'b0) begin $display("FAIL rd_early_rsp got=%b exp=0", rsp_valid); n_err++; end n_vec++;
        tick();
        rsp_ready = 1'b1;
        if ({rsp_valid, rsp_err} !== 2'b10) begin $display("FAIL rd_rsp got=%b exp=10", {rsp_valid, rsp_err}); n_err++; end n_vec++;
        if (rsp_rdata !== 32'hCAFE_0001) begin $display("FAIL rd_rdata got=%h exp=cafe0001", rsp_rdata); n_err++; end n_vec++;
        if ({u_psel, u_penable} !== 2'b00) begin $display("FAIL rd_psel_drop got=%b exp=00", {u_psel, u_penable}); n_err++; end n_vec++;
        tick();
        rsp_ready = 1'b0; u_pready = 1'b0;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin $display("FAIL rd_back_idle got=%b exp=100", {req_ready, rsp_valid, busy}); n_err++; end n_vec++;
    endtask

    task automatic test_gpio_write_wait;
        g_pready = 1'b0; g_pslverr = 1'b0; g_prdata = 32'hBAD0_0BAD;
        req_valid = 1'b1; req_addr = 32'h1A10_1004; req_write = 1'b1; req_wdata = 32'h0000_00FF;
        tick();
        req_valid = 1'b0; req_wdata = 32'h1234_5678; req_write = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if ({g_psel, g_penable} !== {1'b1, c >= 2}) begin $display("FAIL wr_psel_c%0d got=%b exp=%b", c, {g_psel, g_penable}, {1'b1, c >= 2}); n_err++; end n_vec++;
            if ({g_pwrite, g_pwdata, g_paddr} !== {1'b1, 32'h0000_00FF, 12'h004}) begin $display("FAIL wr_bus_c%0d got=%h exp=%h", c, {g_pwrite, g_pwdata, g_paddr}, {1'b1, 32'h0000_00FF, 12'h004}); n_err++; end n_vec++;
            if (u_psel !== 1'b0) begin $display("FAIL wr_udma_psel_c%0d got=%b exp=0", c, u_psel); n_err++; end n_vec++;
            if (c == 4) g_pready = 1'b1;
            tick();
        end
        g_pready = 1'b0; rsp_ready = 1'b1;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0}) begin $display("FAIL wr_rsp_c5 got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0}); n_err++; end n_vec++;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_decode_miss;
        u_pready = 1'b1; g_pready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h2000_0000; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        if ({u_psel, g_psel} !== 2'b00) begin $display("FAIL miss_psel got=%b exp=00", {u_psel, g_psel}); n_err++; end n_vec++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin $display("FAIL miss_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 32'h0}); n_err++; end n_vec++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0; u_pready = 1'b0; g_pready = 1'b0;
        if (req_ready !== 1'b1) begin $display("FAIL miss_back_idle got=%b exp=1", req_ready); n_err++; end n_vec++;
    endtask

    task automatic test_slverr;
        u_pready = 1'b1; u_pslverr = 1'b1; u_prdata = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_addr = 32'h1A10_2FFC; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        if (u_paddr !== 12'hFFC) begin $display("FAIL err_paddr got=%h exp=ffc", u_paddr); n_err++; end n_vec++;
        tick(); tick();
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'hDEAD_BEEF}) begin $display("FAIL err_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 32'hDEAD_BEEF}); n_err++; end n_vec++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0; u_pready = 1'b0; u_pslverr = 1'b0;
    endtask

    task automatic test_timeout;
        g_pready = 1'b0; g_prdata = 32'h5555_AAAA;
        req_valid = 1'b1; req_addr = 32'h1A10_1008; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if ({g_psel, g_penable} !== {1'b1, c >= 2}) begin $display("FAIL to_psel_c%0d got=%b exp=%b", c, {g_psel, g_penable}, {1'b1, c >= 2}); n_err++; end n_vec++;
            if (rsp_valid !== 1'b0) begin $display("FAIL to_early_rsp_c%0d got=%b exp=0", c, rsp_valid); n_err++; end n_vec++;
            tick();
        end
        if ({g_psel, g_penable} !== 2'b00) begin $display("FAIL to_psel_drop got=%b exp=00", {g_psel, g_penable}); n_err++; end n_vec++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin $display("FAIL to_rsp got=%h exp=%h", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 32'h0}); n_err++; end n_vec++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_hold_then_reset;
        u_pready = 1'b1; u_prdata = 32'h1234_5678;
        req_valid = 1'b1; req_addr = 32'h1A10_2020; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        u_prdata = 32'h0;
        for (int c = 0; c < 10; c++) begin
            if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h1234_5678}) begin $display("FAIL hold_rsp_c%0d got=%h exp=%h", c, {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h1234_5678}); n_err++; end n_vec++;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0; u_pready = 1'b0; g_pready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h1A10_1000; req_write = 1'b1; req_wdata = 32'hA5A5_A5A5;
        tick();
        req_valid = 1'b0;
        tick();
        if ({g_psel, g_penable} !== 2'b11) begin $display("FAIL rst2_access got=%b exp=11", {g_psel, g_penable}); n_err++; end n_vec++;
        rst_n = 1'b0; g_pready = 1'b1;
        tick();
        rst_n = 1'b1;
        if ({g_psel, g_penable, u_psel} !== 3'b000) begin $display("FAIL rst2_psel got=%b exp=000", {g_psel, g_penable, u_psel}); n_err++; end n_vec++;
        if ({req_ready, busy, rsp_valid} !== 3'b100) begin $display("FAIL rst2_idle got=%b exp=100", {req_ready, busy, rsp_valid}); n_err++; end n_vec++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (rsp_valid !== 1'b0) begin $display("FAIL rst2_no_rsp_c%0d got=%b exp=0", c, rsp_valid); n_err++; end n_vec++;
        end
        g_pready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0; req_wdata = 32'h0;
        rsp_ready = 1'b0;
        u_prdata = 32'h0; u_pready = 1'b0; u_pslverr = 1'b0;
        g_prdata = 32'h0; g_pready = 1'b0; g_pslverr = 1'b0;
        test_reset();
        test_udma_read();
        test_gpio_write_wait();
        test_decode_miss();
        test_slverr();
        test_timeout();
        test_hold_then_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
